// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: button/wave inputs and display/alarm outputs of the
// countdown-timer sequencer, bundled for connection to timer_ctrl.
//   master modport: drives i_* (stimulus/front panel), reads o_*
//   slave  modport: timer_ctrl side, reads i_*, drives o_*
interface timer_ctrl_if;
  logic       i_clk_100hz;   // square wave from divider, sync to clk
  logic       i_btn_run;     // start/pause/resume/acknowledge pulse
  logic       i_btn_clear;   // abort and zero pulse
  logic       i_btn_min_up;  // minute +1 pulse (IDLE only)
  logic       i_btn_sec_up;  // second +1 pulse (IDLE only)
  logic [5:0] o_min;         // minutes 0..59
  logic [5:0] o_sec;         // seconds 0..59
  logic [6:0] o_csec;        // sub-second count
  logic [1:0] o_state;       // IDLE=0 RUN=1 PAUSE=2 ALARM=3
  logic       o_alarm;       // high while in ALARM
  logic       o_done_pulse;  // one cycle on RUN->ALARM

  modport master (
    output i_clk_100hz, i_btn_run, i_btn_clear, i_btn_min_up, i_btn_sec_up,
    input  o_min, o_sec, o_csec, o_state, o_alarm, o_done_pulse
  );

  modport slave (
    input  i_clk_100hz, i_btn_run, i_btn_clear, i_btn_min_up, i_btn_sec_up,
    output o_min, o_sec, o_csec, o_state, o_alarm, o_done_pulse
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: min:sec countdown-timer sequencer.
//   Turns the 100 Hz divider wave into a one-clk tick enable (the wave is
//   treated as data, never as a clock) and runs an IDLE/RUN/PAUSE/ALARM
//   state machine that counts min:sec.csec down to zero, then holds the
//   alarm for ALARM_SEC seconds.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   timer_ctrl_if.slave: i_clk_100hz, i_btn_run, i_btn_clear,
//         i_btn_min_up, i_btn_sec_up in; o_min, o_sec, o_csec, o_state,
//         o_alarm, o_done_pulse out (all outputs registered)
// Parameters:
//   TICKS_PER_SEC  ticks per second (2..127)
//   ALARM_SEC      alarm duration in seconds (>= 1)
// Build option:
//   TIMER_CTRL_AUTO_RELOAD_EN  keep a preset of min:sec captured on every
//   start; returning to IDLE (clear, alarm timeout, acknowledge) reloads it.
//   Clear while in IDLE zeroes time and preset. Undefined: returns to IDLE
//   always zero the time.
module timer_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int ALARM_SEC     = 5
) (
  input logic          clk,
  input logic          rst,
  timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam int              ALM_TICKS = ALARM_SEC * TICKS_PER_SEC;
  localparam int              AW        = $clog2(ALM_TICKS + 1);
  localparam logic [AW-1:0]   ALM_LAST  = AW'(ALM_TICKS - 1);
  localparam logic [6:0]      CSEC_TOP  = 7'(TICKS_PER_SEC - 1);

  state_t        r_state;
  logic          r_prev;
  logic [5:0]    r_min, r_sec;
  logic [6:0]    r_csec;
  logic          r_alarm, r_done;
  logic [AW-1:0] r_alm_cnt;

  logic          w_tick, w_run, w_clr, w_mu, w_su;
  logic          w_set_nz, w_last;
  logic [5:0]    w_rl_min, w_rl_sec;

  assign w_run = bus.i_btn_run;
  assign w_clr = bus.i_btn_clear;
  assign w_mu  = bus.i_btn_min_up;
  assign w_su  = bus.i_btn_sec_up;

  // Rising-edge detect on the divider wave: one clk per edge. prev resets
  // low so a wave already high at reset release yields the first tick.
  assign w_tick = bus.i_clk_100hz & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= bus.i_clk_100hz;
  end

  assign w_set_nz = (r_min != 6'd0) || (r_sec != 6'd0);
  // This tick takes the count to 0:00.00; the borrow path never sees zero.
  assign w_last   = (r_csec == 7'd1) && !w_set_nz;

`ifdef TIMER_CTRL_AUTO_RELOAD_EN
  logic [5:0] r_pre_min, r_pre_sec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_min <= 6'd0;
      r_pre_sec <= 6'd0;
    end else if (r_state == S_IDLE) begin
      if (w_clr) begin
        r_pre_min <= 6'd0;
        r_pre_sec <= 6'd0;
      end else if (w_run && w_set_nz) begin
        r_pre_min <= r_min;
        r_pre_sec <= r_sec;
      end
    end
  end

  assign w_rl_min = r_pre_min;
  assign w_rl_sec = r_pre_sec;
`else
  assign w_rl_min = 6'd0;
  assign w_rl_sec = 6'd0;
`endif

  // Single registered FSM. Priority clear > run > set buttons / tick; an
  // accepted run or clear swallows a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_csec    <= 7'd0;
      r_alarm   <= 1'b0;
      r_done    <= 1'b0;
      r_alm_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_clr) begin
            r_min  <= 6'd0;
            r_sec  <= 6'd0;
            r_csec <= 7'd0;
          end else if (w_run) begin
            // A start at 0:00 is ignored; set buttons lose to run.
            if (w_set_nz) begin
              r_state <= S_RUN;
              r_csec  <= 7'd0;
            end
          end else begin
            if (w_mu) r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (w_su) r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
          end
        end

        S_RUN: begin
          if (w_clr) begin
            r_state <= S_IDLE;
            r_min   <= w_rl_min;
            r_sec   <= w_rl_sec;
            r_csec  <= 7'd0;
          end else if (w_run) begin
            r_state <= S_PAUSE;
          end else if (w_tick) begin
            if (r_csec != 7'd0) begin
              r_csec <= r_csec - 7'd1;
              if (w_last) begin
                r_state   <= S_ALARM;
                r_alarm   <= 1'b1;
                r_done    <= 1'b1;
                r_alm_cnt <= '0;
              end
            end else begin
              r_csec <= CSEC_TOP;
              if (r_sec == 6'd0) begin
                r_sec <= 6'd59;
                r_min <= r_min - 6'd1;
              end else begin
                r_sec <= r_sec - 6'd1;
              end
            end
          end
        end

        S_PAUSE: begin
          if (w_clr) begin
            r_state <= S_IDLE;
            r_min   <= w_rl_min;
            r_sec   <= w_rl_sec;
            r_csec  <= 7'd0;
          end else if (w_run) begin
            r_state <= S_RUN;
          end
        end

        S_ALARM: begin
          // Time already reads 0:00.00 on entry; leave via ack or timeout.
          if (w_clr || w_run || (w_tick && r_alm_cnt == ALM_LAST)) begin
            r_state <= S_IDLE;
            r_alarm <= 1'b0;
            r_min   <= w_rl_min;
            r_sec   <= w_rl_sec;
            r_csec  <= 7'd0;
          end else if (w_tick) begin
            r_alm_cnt <= r_alm_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_min        = r_min;
  assign bus.o_sec        = r_sec;
  assign bus.o_csec       = r_csec;
  assign bus.o_state      = r_state;
  assign bus.o_alarm      = r_alarm;
  assign bus.o_done_pulse = r_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl (TICKS_PER_SEC=4,
// ALARM_SEC=2, divider wave toggling every 3 clk). A reference model keeps
// the remaining run time as a single tick count and derives min:sec.csec
// arithmetically; every cycle is compared against it, plus a vector table
// and hand sequences with fixed expected values.
module tb_timer_ctrl;
  localparam int T  = 4;
  localparam int AS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_ctrl_if bus();

  timer_ctrl #(.TICKS_PER_SEC(T), .ALARM_SEC(AS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_seen = 0;

  // Reference model state
  int   m_st, m_im, m_is, m_rem, m_acnt, m_pm, m_ps;
  logic m_prev, m_done;

  function automatic logic wave_at(input int c);
    return ((c / 3) % 2) == 1;
  endfunction

  function automatic int e_min();
    if (m_st == 0) return m_im;
    if (m_st == 3) return 0;
    return m_rem / (60 * T);
  endfunction
  function automatic int e_sec();
    if (m_st == 0) return m_is;
    if (m_st == 3) return 0;
    return (m_rem / T) % 60;
  endfunction
  function automatic int e_csec();
    if (m_st == 1 || m_st == 2) return m_rem % T;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_im = 0; m_is = 0; m_rem = 0; m_acnt = 0;
    m_pm = 0; m_ps = 0; m_prev = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_idle();
    m_st = 0;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    m_im = m_pm; m_is = m_ps;
`else
    m_im = 0; m_is = 0;
`endif
  endtask

  task automatic model_step(input logic run, clr, mu, su, w);
    logic tick;
    tick = w & ~m_prev;
    m_prev = w;
    m_done = 1'b0;
    case (m_st)
      0: begin
        if (clr) begin
          m_im = 0; m_is = 0; m_pm = 0; m_ps = 0;
        end else if (run) begin
          if (m_im != 0 || m_is != 0) begin
            m_rem = (60 * m_im + m_is) * T;
            m_pm = m_im; m_ps = m_is;
            m_st = 1;
          end
        end else begin
          if (mu) m_im = (m_im + 1) % 60;
          if (su) m_is = (m_is + 1) % 60;
        end
      end
      1: begin
        if (clr) model_idle();
        else if (run) m_st = 2;
        else if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_st = 3; m_done = 1'b1; m_acnt = 0; end
        end
      end
      2: begin
        if (clr) model_idle();
        else if (run) m_st = 1;
      end
      default: begin
        if (clr || run) model_idle();
        else if (tick) begin
          m_acnt = m_acnt + 1;
          if (m_acnt == AS * T) model_idle();
        end
      end
    endcase
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clk: drive inputs, advance model at the edge, compare just after.
  task automatic step(input logic run, clr, mu, su);
    logic w;
    int ea;
    w = wave_at(cyc);
    cyc++;
    bus.i_clk_100hz  = w;
    bus.i_btn_run    = run;
    bus.i_btn_clear  = clr;
    bus.i_btn_min_up = mu;
    bus.i_btn_sec_up = su;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(run, clr, mu, su, w);
    #1;
    done_seen += int'(bus.o_done_pulse);
    ea = (m_st == 3) ? 1 : 0;
    n_tests++;
    if (int'(bus.o_state) != m_st || int'(bus.o_min) != e_min() ||
        int'(bus.o_sec) != e_sec() || int'(bus.o_csec) != e_csec() ||
        int'(bus.o_alarm) != ea || int'(bus.o_done_pulse) != int'(m_done)) begin
      n_fail++;
      $display("FAIL model cyc%0d: got st=%0d %0d:%0d.%0d al=%0d dn=%0d, expected st=%0d %0d:%0d.%0d al=%0d dn=%0d",
               cyc, bus.o_state, bus.o_min, bus.o_sec, bus.o_csec, bus.o_alarm,
               bus.o_done_pulse, m_st, e_min(), e_sec(), e_csec(), ea, m_done);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Step until n ticks of the bench's own wave have been presented.
  task automatic run_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      if (wave_at(cyc) && !wave_at(cyc - 1)) k++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Stop so that the next step() lands on a tick.
  task automatic wait_pre_tick();
    while (!(wave_at(cyc) && !wave_at(cyc - 1))) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_time(input string nm, input int st, input int mi, input int se, input int cs);
    check({nm, "_state"}, int'(bus.o_state), st);
    check({nm, "_time"}, int'(bus.o_min) * 10000 + int'(bus.o_sec) * 100 + int'(bus.o_csec),
          mi * 10000 + se * 100 + cs);
  endtask

  typedef struct {
    logic run, clr, mu, su;
    int   st, mi, se, cs;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int d0;
    model_reset();
    bus.i_clk_100hz = 1'b0; bus.i_btn_run = 1'b0; bus.i_btn_clear = 1'b0;
    bus.i_btn_min_up = 1'b0; bus.i_btn_sec_up = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};  // run at 0:00 ignored
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 2, 0};  // both apply
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1, 0};  // set ignored in PAUSE
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0};
`else
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
`endif
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};

    // Reset
    idle_steps(2);
    check("reset_state", int'(bus.o_state), 0);
    check("reset_outs", int'({bus.o_min, bus.o_sec, bus.o_csec, bus.o_alarm, bus.o_done_pulse}), 0);
    rst = 1'b0;
    idle_steps(2);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].run, tbl[i].clr, tbl[i].mu, tbl[i].su);
      chk_time($sformatf("tbl%0d", i), tbl[i].st, tbl[i].mi, tbl[i].se, tbl[i].cs);
    end

    // Setup: sec wraps without carry, minute increments
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_at_zero", int'(bus.o_state), 0);
    for (int i = 0; i < 61; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_time("sec61", 0, 0, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_time("min2", 0, 2, 1, 0);

    // Countdown 0:02
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    d0 = done_seen;
    run_ticks(1);
    chk_time("cd_tick1", 1, 0, 1, 3);
    run_ticks(7);
    chk_time("cd_alarm", 3, 0, 0, 0);
    check("cd_alarm_out", int'(bus.o_alarm), 1);
    run_ticks(7);
    check("alarm_hold", int'(bus.o_state), 3);
    run_ticks(1);
    check("alarm_timeout", int'(bus.o_state), 0);
    check("alarm_off", int'(bus.o_alarm), 0);
    check("done_once", done_seen - d0, 1);

    // Pause / resume from 1:00
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(5);
    chk_time("pr_run5", 1, 0, 58, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(10);
    chk_time("pr_paused", 2, 0, 58, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(1);
    chk_time("pr_resume", 1, 0, 58, 2);

    // Clear + run on a tick in RUN
    wait_pre_tick();
    step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    chk_time("prio_clr", 0, 1, 0, 0);
`else
    chk_time("prio_clr", 0, 0, 0, 0);
`endif

    // Acknowledge in ALARM
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(4);
    check("ack_in_alarm", int'(bus.o_state), 3);
    d0 = done_seen;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ack_idle", int'(bus.o_state), 0);
    check("ack_alarm_off", int'(bus.o_alarm), 0);
    idle_steps(6);
    check("ack_no_done", done_seen - d0, 0);

    // Reset mid-RUN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(2);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_time("rst_run", 0, 0, 0, 0);
    check("rst_alarm", int'(bus.o_alarm), 0);
    rst = 1'b0;
    idle_steps(2);

`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    // Reload after timeout; clear in IDLE wipes the preset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(12 + 8);
    chk_time("rl_003", 0, 0, 3, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_time("rl_clr", 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(4 + 8);
    chk_time("rl_001", 0, 0, 1, 0);
`endif

    // Randomized run against the model
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 399) == 0, $urandom_range(0, 99) == 0);
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
